// File: rtl/multicycle_ctrl_fsm_if.sv
// Signal bundle between the instruction register/datapath side and multicycle_ctrl_fsm.
interface multicycle_ctrl_fsm_if #(
    parameter int OPW  = 6,
    parameter int FW   = 5,
    parameter int ALUW = 4
);
    // Memory handshake: rdMem/wrMem rises on the first S_MEM cycle and stays high until the
    // cycle in which mem_ack is sampled high (or the wait times out); mem_ack outside a request is ignored.
    logic [OPW-1:0]  opcode;
    logic [FW-1:0]   func;
    logic            INT;
    logic            mem_ack;
    logic [ALUW-1:0] aluOp;
    logic [2:0]      brOp;
    logic            aluSrc;
    logic            regAluOut;
    logic            rdMem;
    logic            wrMem;
    logic            wrReg;
    logic            mToReg;
    logic            immSel;
    logic            updPC;
    logic            isCmov;
    logic            halted;
    logic            ill_op;
    logic            mem_err;
    logic [2:0]      state_o;

    modport master (
        input  opcode, func, INT, mem_ack,
        output aluOp, brOp, aluSrc, regAluOut, rdMem, wrMem, wrReg, mToReg,
               immSel, updPC, isCmov, halted, ill_op, mem_err, state_o
    );

    modport slave (
        output opcode, func, INT, mem_ack,
        input  aluOp, brOp, aluSrc, regAluOut, rdMem, wrMem, wrReg, mToReg,
               immSel, updPC, isCmov, halted, ill_op, mem_err, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit: sequences FETCH..DONE and drives a fully registered control word,
// with interrupt-released HALT, memory-wait timeout and sticky illegal-opcode detection.
module multicycle_ctrl_fsm #(
    parameter int OPW      = 6,
    parameter int FW       = 5,
    parameter int ALUW     = 4,
    parameter int EXEC_CYC = 1,
    parameter int MEM_TMO  = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multicycle_ctrl_fsm_if.master bus
);
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b010000);
    localparam logic [OPW-1:0] OP_MOVE  = OPW'(6'b010001);
    localparam logic [OPW-1:0] OP_CMOV  = OPW'(6'b010010);
    localparam logic [OPW-1:0] OP_LD    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_ST    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BR    = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_BMI   = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BPL   = OPW'(6'b110010);
    localparam logic [OPW-1:0] OP_BZ    = OPW'(6'b110011);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111110);
    localparam logic [OPW-1:0] OP_NOP   = OPW'(6'b111111);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM  = 3'd3,
        S_WB    = 3'd4, S_DONE   = 3'd5, S_HALT = 3'd6, S_ERR  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_LUI, C_MOVE, C_CMOV, C_LD, C_ST, C_BR, C_HALT, C_NOP, C_ILL
    } cls_t;

    typedef struct packed {
        logic [ALUW-1:0] alu_op;
        logic [2:0]      br_op;
        logic            alu_src;
        logic            reg_alu_out;
        logic            rd_mem;
        logic            wr_mem;
        logic            wr_reg;
        logic            m_to_reg;
        logic            imm_sel;
        logic            upd_pc;
        logic            is_cmov;
        logic            halted;
        logic            ill_op;
        logic            mem_err;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{br_op: 3'b100, default: '0};

    function automatic cls_t classify(input logic [OPW-1:0] op);
        cls_t c;
        case (op)
            OP_LUI:                      c = C_LUI;
            OP_MOVE:                     c = C_MOVE;
            OP_CMOV:                     c = C_CMOV;
            OP_LD:                       c = C_LD;
            OP_ST:                       c = C_ST;
            OP_BR, OP_BMI, OP_BPL, OP_BZ: c = C_BR;
            OP_HALT:                     c = C_HALT;
            OP_NOP:                      c = C_NOP;
            default:                     c = (op <= OPW'(15)) ? C_ALU : C_ILL;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic [4:0] exec_q, exec_d;
    logic [7:0] mem_q, mem_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       go_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
            exec_q  <= '0;
            mem_q   <= '0;
            ctrl_q  <= CTRL_RST;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            exec_q  <= exec_d;
            mem_q   <= mem_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Outputs are computed for the state being entered, so they line up with state_o.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        exec_d  = exec_q;
        mem_d   = mem_q;
        ctrl_d  = ctrl_q;
        go_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                cls_d          = classify(bus.opcode);
                ctrl_d         = CTRL_RST;
                ctrl_d.ill_op  = ctrl_q.ill_op;
                ctrl_d.mem_err = ctrl_q.mem_err;
                case (cls_d)
                    C_ALU: begin
                        if (bus.opcode == OP_RTYPE) begin
                            ctrl_d.alu_op      = ALUW'(bus.func[3:0] - 4'd1);
                            ctrl_d.alu_src     = 1'b1;
                            ctrl_d.reg_alu_out = 1'b1;
                        end else begin
                            ctrl_d.alu_op = ALUW'(bus.opcode[3:0] - 4'd1);
                        end
                    end
                    C_LUI:  ctrl_d.alu_op = '1;
                    C_MOVE, C_CMOV: begin
                        ctrl_d.alu_src     = 1'b1;
                        ctrl_d.reg_alu_out = 1'b1;
                        ctrl_d.is_cmov     = (cls_d == C_CMOV);
                    end
                    C_BR: begin
                        ctrl_d.br_op   = {1'b0, bus.opcode[1:0]};
                        ctrl_d.imm_sel = 1'b1;
                    end
                    default: ;
                endcase
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (cls_q)
                    C_HALT: begin
                        ctrl_d.halted = 1'b1;
                        state_d       = S_HALT;
                    end
                    C_NOP: go_done = 1'b1;
                    C_ILL: begin
                        ctrl_d.ill_op = 1'b1;
                        go_done       = 1'b1;
                    end
                    default: begin
                        exec_d  = (cls_q == C_CMOV) ? 5'(EXEC_CYC + 1) : 5'(EXEC_CYC);
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                if (exec_q > 5'd1) begin
                    exec_d = exec_q - 5'd1;
                end else begin
                    case (cls_q)
                        C_LD, C_ST: begin
                            ctrl_d.rd_mem = (cls_q == C_LD);
                            ctrl_d.wr_mem = (cls_q == C_ST);
                            mem_d         = 8'd1;
                            state_d       = S_MEM;
                        end
                        C_BR: go_done = 1'b1;
                        default: begin
                            ctrl_d.wr_reg = 1'b1;
                            state_d       = S_WB;
                        end
                    endcase
                end
            end
            S_MEM: begin
                // An ack in the timeout cycle still completes the access.
                if (bus.mem_ack) begin
                    ctrl_d.rd_mem = 1'b0;
                    ctrl_d.wr_mem = 1'b0;
                    if (cls_q == C_LD) begin
                        ctrl_d.wr_reg   = 1'b1;
                        ctrl_d.m_to_reg = 1'b1;
                        state_d         = S_WB;
                    end else begin
                        go_done = 1'b1;
                    end
                end else if (mem_q >= 8'(MEM_TMO)) begin
                    ctrl_d.rd_mem  = 1'b0;
                    ctrl_d.wr_mem  = 1'b0;
                    ctrl_d.mem_err = 1'b1;
                    state_d        = S_ERR;
                end else begin
                    mem_d = mem_q + 8'd1;
                end
            end
            S_WB: go_done = 1'b1;
            S_DONE: begin
                ctrl_d.upd_pc  = 1'b0;
                ctrl_d.is_cmov = 1'b0;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                if (bus.INT) begin
                    ctrl_d.halted = 1'b0;
                    go_done       = 1'b1;
                end
            end
            default: ;
        endcase
        if (go_done) begin
            ctrl_d.wr_reg   = 1'b0;
            ctrl_d.m_to_reg = 1'b0;
            ctrl_d.rd_mem   = 1'b0;
            ctrl_d.wr_mem   = 1'b0;
            ctrl_d.br_op    = 3'b100;
            ctrl_d.upd_pc   = 1'b1;
            state_d         = S_DONE;
        end
    end

    assign bus.aluOp     = ctrl_q.alu_op;
    assign bus.brOp      = ctrl_q.br_op;
    assign bus.aluSrc    = ctrl_q.alu_src;
    assign bus.regAluOut = ctrl_q.reg_alu_out;
    assign bus.rdMem     = ctrl_q.rd_mem;
    assign bus.wrMem     = ctrl_q.wr_mem;
    assign bus.wrReg     = ctrl_q.wr_reg;
    assign bus.mToReg    = ctrl_q.m_to_reg;
    assign bus.immSel    = ctrl_q.imm_sel;
    assign bus.updPC     = ctrl_q.upd_pc;
    assign bus.isCmov    = ctrl_q.is_cmov;
    assign bus.halted    = ctrl_q.halted;
    assign bus.ill_op    = ctrl_q.ill_op;
    assign bus.mem_err   = ctrl_q.mem_err;
    assign bus.state_o   = state_q;
endmodule
